// File: rtl/block_sequencer_pkg.sv
// block_sequencer_pkg: shared shape, rotation, LFSR and FSM definitions for the piece sequencer
package block_sequencer_pkg;
  typedef enum logic [2:0] {SH_I, SH_O, SH_S, SH_Z, SH_L, SH_J, SH_T} shape_e;
  typedef enum logic [1:0] {FILL, IDLE, DRAW} state_e;
  localparam logic [15:0] LFSR_RESET_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [4:0] BASE_CODE [7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  function automatic logic [4:0] base_code(shape_e s);
    return BASE_CODE[s];
  endfunction
  function automatic logic [4:0] rot_cw(logic [4:0] c);
    case (c)
      5'd0: return 5'd7;
      5'd7: return 5'd0;
      5'd1: return 5'd1;
      5'd2: return 5'd8;
      5'd8: return 5'd2;
      5'd3: return 5'd9;
      5'd9: return 5'd3;
      5'd4: return 5'd10;
      5'd10: return 5'd11;
      5'd11: return 5'd12;
      5'd12: return 5'd4;
      5'd5: return 5'd13;
      5'd13: return 5'd14;
      5'd14: return 5'd15;
      5'd15: return 5'd5;
      5'd6: return 5'd16;
      5'd16: return 5'd17;
      5'd17: return 5'd18;
      5'd18: return 5'd6;
      default: return 5'd0;
    endcase
  endfunction
  function automatic logic [4:0] rot_ccw(logic [4:0] c);
    case (c)
      5'd0: return 5'd7;
      5'd7: return 5'd0;
      5'd1: return 5'd1;
      5'd2: return 5'd8;
      5'd8: return 5'd2;
      5'd3: return 5'd9;
      5'd9: return 5'd3;
      5'd4: return 5'd12;
      5'd12: return 5'd11;
      5'd11: return 5'd10;
      5'd10: return 5'd4;
      5'd5: return 5'd15;
      5'd15: return 5'd14;
      5'd14: return 5'd13;
      5'd13: return 5'd5;
      5'd6: return 5'd18;
      5'd18: return 5'd17;
      5'd17: return 5'd16;
      5'd16: return 5'd6;
      default: return 5'd0;
    endcase
  endfunction
endpackage

// File: rtl/block_sequencer_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running with seed load
// Ports: clk_i, rst_ni (sync active-low), seed_load_i/seed_i (zero seed maps to RESET_VAL), state_o.
module lfsr16
  import block_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR_RESET_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        seed_load_i,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);
  logic [15:0] state_q;
  assign state_o = state_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= RESET_VAL;
    else if (seed_load_i) state_q <= seed_i == 16'd0 ? RESET_VAL : seed_i;
    else state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
  end
endmodule

// File: rtl/block_sequencer.sv
// block_sequencer: 7-bag tetromino picker with one-piece preview and active-piece rotation
// Ports: clk_i, rst_ni (sync active-low); seed_load_i/seed_i reseed the LFSR;
// spawn_req_i, rotate_cw_i, rotate_ccw_i from the game FSM; ready_o (preview valid),
// spawn_done_o (one-cycle pulse), piece_active_o, current_block_type_o (0..18), next_piece_o (0..6).
module block_sequencer
  import block_sequencer_pkg::*;
#(
  parameter logic [15:0] LFSR_RESET = LFSR_RESET_DEFAULT,
  parameter int unsigned MAX_TRIES  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        seed_load_i,
  input  logic [15:0] seed_i,
  input  logic        spawn_req_i,
  input  logic        rotate_cw_i,
  input  logic        rotate_ccw_i,
  output logic        ready_o,
  output logic        spawn_done_o,
  output logic        piece_active_o,
  output logic [4:0]  current_block_type_o,
  output logic [2:0]  next_piece_o
);
  logic [15:0] lfsr;
  logic        lfsr_unused;
  state_e      state_q;
  logic [6:0]  bag_q, bag_set, bag_d;
  logic [7:0]  bag_ext;
  logic [3:0]  tries_q;
  logic [2:0]  next_q, low, pick;
  logic [4:0]  code_q, rot_d;
  logic        ready_q, done_q, active_q, cand_ok, accept, spawn, rot_en;
  lfsr16 #(.RESET_VAL(LFSR_RESET)) u_lfsr (
    .clk_i,
    .rst_ni,
    .seed_load_i,
    .seed_i,
    .state_o(lfsr)
  );
  assign lfsr_unused = ^lfsr[15:3];
  always_comb begin
    low = 3'd0;
    for (int k = 6; k >= 0; k--) low = bag_q[k] ? low : 3'(k);
    // candidate 7 is never a shape, so it reads as permanently used
    bag_ext = {1'b1, bag_q};
    cand_ok = !bag_ext[lfsr[2:0]];
    pick    = cand_ok ? lfsr[2:0] : low;
    accept  = state_q != IDLE && (cand_ok || tries_q == 4'(MAX_TRIES));
    bag_set = bag_q | (7'd1 << pick);
    bag_d   = &bag_set ? 7'd0 : bag_set;
    spawn   = state_q == IDLE && spawn_req_i;
    rot_en  = active_q && !spawn && (rotate_cw_i ^ rotate_ccw_i);
    rot_d   = rotate_cw_i ? rot_cw(code_q) : rot_ccw(code_q);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= FILL;
      bag_q    <= 7'd0;
      tries_q  <= 4'd0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      code_q   <= 5'd0;
      next_q   <= 3'd0;
    end else begin
      done_q <= spawn;
      if (spawn) begin
        code_q   <= base_code(shape_e'(next_q));
        active_q <= 1'b1;
        ready_q  <= 1'b0;
        state_q  <= DRAW;
      end else if (rot_en) begin
        code_q <= rot_d;
      end
      if (state_q != IDLE) begin
        if (accept) begin
          next_q  <= pick;
          bag_q   <= bag_d;
          tries_q <= 4'd0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end else begin
          tries_q <= tries_q + 4'd1;
        end
      end
    end
  end
  assign ready_o              = ready_q;
  assign spawn_done_o         = done_q;
  assign piece_active_o       = active_q;
  assign current_block_type_o = code_q;
  assign next_piece_o         = next_q;
endmodule
